// File: rtl/rca_opload_pkg.sv
// Shared types for the 3-operand adder loader: FSM states and the registered operand bundle.
// Pure declarations; no timing or handshake behaviour lives here.
package rca_opload_pkg;
    localparam int OPLOAD_W    = 16;
    localparam int OPLOAD_NOPS = 3;

    typedef enum logic [1:0] {GET_A, GET_B, GET_C} opload_state_t;

    typedef struct packed {
        logic [OPLOAD_W-1:0] a;
        logic [OPLOAD_W-1:0] b;
        logic [OPLOAD_W-1:0] c;
        logic                cin;
    } opload_bundle_t;
endpackage

// File: rtl/rca_opload_outreg.sv
// Output register for one operand bundle with its valid flag.
// Latency: load at cycle t is visible at t+1. Backpressure: holds bundle while op_ready_i=0.
// Accepts a new load in the same cycle the current bundle is taken.
module rca_opload_outreg
    import rca_opload_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           ld_vld_i,
    input  opload_bundle_t ld_dat_i,
    output logic           ld_rdy_o,
    output opload_bundle_t op_dat_o,
    output logic           op_vld_o,
    input  logic           op_rdy_i
);
    opload_bundle_t bundle_q;
    logic           vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_q <= '0;
            vld_q    <= 1'b0;
        end else if (ld_vld_i) begin
            bundle_q <= ld_dat_i;
            vld_q    <= 1'b1;
        end else if (vld_q && op_rdy_i) begin
            vld_q    <= 1'b0;
        end
    end

    assign ld_rdy_o = !vld_q || op_rdy_i;
    assign op_dat_o = bundle_q;
    assign op_vld_o = vld_q;
endmodule

// File: rtl/rca_operand_loader.sv
// Packs a serial word stream into registered {A,B,C,cin} bundles for the 3-operand adder.
// Latency: word C accepted at t -> op_valid at t+1. Backpressure: in_ready drops only in GET_C.
// Optional macro RCA_OPLOAD_SUBTRACT_EN adds in_sub for A+B-C operation.
module rca_operand_loader
    import rca_opload_pkg::*;
#(
    parameter int W    = 16,
    parameter int NOPS = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_cin,
`ifdef RCA_OPLOAD_SUBTRACT_EN
    input  logic         in_sub,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         abort,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic [W-1:0] op_c,
    output logic         op_cin,
    output logic         op_valid,
    input  logic         op_ready,
    output logic         err_abort
);
    if (NOPS != OPLOAD_NOPS) begin : g_bad_nops
        $error("rca_operand_loader: NOPS must be 3");
    end
    if (W != OPLOAD_W) begin : g_bad_w
        $error("rca_operand_loader: W must equal OPLOAD_W");
    end

    opload_state_t  state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic           cin_q, cin_d;
    logic           sub_q, sub_d;
    logic           err_q, err_d;
    logic           c_rdy, accept, load;
    opload_bundle_t ld_dat, op_dat;

    // abort wins over any accept, so the word on the bus that cycle is refused
    assign in_ready = !abort && ((state_q != GET_C) || c_rdy);
    assign accept   = in_valid && in_ready;
    assign load     = accept && (state_q == GET_C);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        sub_d   = sub_q;
        err_d   = 1'b0;
        if (abort) begin
            state_d = GET_A;
            err_d   = (state_q == GET_B) || (state_q == GET_C);
        end else if (accept) begin
            case (state_q)
                GET_A: begin
                    a_d     = in_data;
                    cin_d   = in_cin;
`ifdef RCA_OPLOAD_SUBTRACT_EN
                    sub_d   = in_sub;
`else
                    sub_d   = 1'b0;
`endif
                    state_d = GET_B;
                end
                GET_B: begin
                    b_d     = in_data;
                    state_d = GET_C;
                end
                GET_C:   state_d = GET_A;
                default: state_d = GET_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GET_A;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            sub_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            sub_q   <= sub_d;
            err_q   <= err_d;
        end
    end

    // subtract mode forms A+B+~C+1 so the adder produces A+B-C
    assign ld_dat.a   = a_q;
    assign ld_dat.b   = b_q;
    assign ld_dat.c   = sub_q ? ~in_data : in_data;
    assign ld_dat.cin = sub_q ? 1'b1 : cin_q;

    rca_opload_outreg u_outreg (
        .clk      (clk),
        .rst      (rst),
        .ld_vld_i (load),
        .ld_dat_i (ld_dat),
        .ld_rdy_o (c_rdy),
        .op_dat_o (op_dat),
        .op_vld_o (op_valid),
        .op_rdy_i (op_ready)
    );

    assign op_a      = op_dat.a;
    assign op_b      = op_dat.b;
    assign op_c      = op_dat.c;
    assign op_cin    = op_dat.cin;
    assign err_abort = err_q;
endmodule

// File: tb/tb_rca_operand_loader.sv
// Directed self-checking bench for rca_operand_loader.
module tb_rca_operand_loader;
    import rca_opload_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_cin;
    logic        in_sub;
    logic        in_valid;
    logic        in_ready;
    logic        abort;
    logic [15:0] op_a, op_b, op_c;
    logic        op_cin, op_valid, op_ready, err_abort;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rca_operand_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_cin    (in_cin),
`ifdef RCA_OPLOAD_SUBTRACT_EN
        .in_sub    (in_sub),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .abort     (abort),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_c      (op_c),
        .op_cin    (op_cin),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .err_abort (err_abort)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic c);
        in_data  = d;
        in_cin   = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_bundle(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic ci);
        chk({tag, ".vld"}, 32'(op_valid), 32'd1);
        chk({tag, ".a"},   32'(op_a),     32'(a));
        chk({tag, ".b"},   32'(op_b),     32'(b));
        chk({tag, ".c"},   32'(op_c),     32'(c));
        chk({tag, ".cin"}, 32'(op_cin),   32'(ci));
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_cin = 1'b0; in_sub = 1'b0;
        in_valid = 1'b0; abort = 1'b0; op_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst.vld",   32'(op_valid),  32'd0);
        chk("rst.a",     32'(op_a),      32'd0);
        chk("rst.c",     32'(op_c),      32'd0);
        chk("rst.cin",   32'(op_cin),    32'd0);
        chk("rst.err",   32'(err_abort), 32'd0);
        chk("rst.rdy",   32'(in_ready),  32'd1);
        chk("rst.state", 32'(dut.state_q), 32'(GET_A));

        // Basic triple
        send(16'h0001, 1'b1);
        send(16'h0002, 1'b0);
        chk("t1.novld", 32'(op_valid), 32'd0);
        send(16'h0003, 1'b0);
        chk_bundle("t1", 16'h0001, 16'h0002, 16'h0003, 1'b1);
        tick();
        chk("t1.drain", 32'(op_valid), 32'd0);

        // Nine back-to-back words, no bubbles
        for (int i = 0; i < 9; i++) begin
            in_data  = 16'h0100 + 16'(i);
            in_cin   = ((i / 3) % 2) == 1;
            in_valid = 1'b1;
            #1;
            chk($sformatf("t2.rdy%0d", i), 32'(in_ready), 32'd1);
            tick();
            chk($sformatf("t2.vld%0d", i), 32'(op_valid), 32'((i % 3) == 2));
            if ((i % 3) == 2)
                chk_bundle($sformatf("t2.b%0d", i / 3), 16'h0100 + 16'(i - 2),
                           16'h0100 + 16'(i - 1), 16'h0100 + 16'(i), ((i / 3) % 2) == 1);
        end
        in_valid = 1'b0;
        tick();
        chk("t2.drain", 32'(op_valid), 32'd0);

        // Backpressure in GET_C, then take-and-reload in one cycle
        op_ready = 1'b0;
        send(16'h0011, 1'b0);
        send(16'h0012, 1'b0);
        send(16'h0013, 1'b0);
        chk_bundle("t3.first", 16'h0011, 16'h0012, 16'h0013, 1'b0);
        send(16'h0021, 1'b1);
        send(16'h0022, 1'b0);
        in_data = 16'h0023; in_valid = 1'b1;
        #1;
        chk("t3.rdy0", 32'(in_ready), 32'd0);
        tick();
        tick();
        chk_bundle("t3.hold", 16'h0011, 16'h0012, 16'h0013, 1'b0);
        chk("t3.state", 32'(dut.state_q), 32'(GET_C));
        op_ready = 1'b1;
        #1;
        chk("t3.rdy1", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk_bundle("t3.second", 16'h0021, 16'h0022, 16'h0023, 1'b1);
        tick();
        chk("t3.drain", 32'(op_valid), 32'd0);

        // Abort of a partial triple
        send(16'hFFFF, 1'b1);
        send(16'hFFFF, 1'b0);
        in_data = 16'h5555; in_valid = 1'b1; abort = 1'b1;
        #1;
        chk("t4.rdy", 32'(in_ready), 32'd0);
        tick();
        abort = 1'b0; in_valid = 1'b0;
        chk("t4.err1",  32'(err_abort), 32'd1);
        chk("t4.state", 32'(dut.state_q), 32'(GET_A));
        chk("t4.novld", 32'(op_valid), 32'd0);
        tick();
        chk("t4.err0", 32'(err_abort), 32'd0);
        op_ready = 1'b0;
        send(16'h0010, 1'b0);
        send(16'h0020, 1'b0);
        send(16'h0030, 1'b0);
        chk_bundle("t4.next", 16'h0010, 16'h0020, 16'h0030, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4.errA", 32'(err_abort), 32'd0);
        chk_bundle("t4.keep", 16'h0010, 16'h0020, 16'h0030, 1'b0);
        op_ready = 1'b1;
        tick();
        chk("t4.drain", 32'(op_valid), 32'd0);

        // Reset in GET_C with a pending bundle
        op_ready = 1'b0;
        send(16'h0041, 1'b1);
        send(16'h0042, 1'b0);
        send(16'h0043, 1'b0);
        send(16'h0051, 1'b0);
        send(16'h0052, 1'b0);
        chk("t5.pre", 32'(op_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t5.vld",   32'(op_valid), 32'd0);
        chk("t5.a",     32'(op_a),     32'd0);
        chk("t5.b",     32'(op_b),     32'd0);
        chk("t5.c",     32'(op_c),     32'd0);
        chk("t5.cin",   32'(op_cin),   32'd0);
        chk("t5.err",   32'(err_abort), 32'd0);
        chk("t5.rdy",   32'(in_ready), 32'd1);
        chk("t5.state", 32'(dut.state_q), 32'(GET_A));

`ifdef RCA_OPLOAD_SUBTRACT_EN
        op_ready = 1'b1;
        in_sub = 1'b1;
        send(16'h0005, 1'b0);
        in_sub = 1'b0;
        send(16'h0007, 1'b0);
        send(16'h0003, 1'b0);
        chk_bundle("t6.sub", 16'h0005, 16'h0007, 16'hFFFC, 1'b1);
        chk("t6.sum", 32'(16'(op_a + op_b + op_c + 16'(op_cin))), 32'h0009);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
